// File: rtl/bus_pack_fifo.sv
// bus_pack_fifo: packs pairs of 64-bit writes into a 128-bit show-ahead FIFO.
// Define BUS_PACK_FLUSH_EN to add a flush input that pushes a lone pending half.
module bus_pack_fifo #(
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  write_data,
   input  logic         write_en,
   input  logic         read,
`ifdef BUS_PACK_FLUSH_EN
   input  logic         flush,
`endif
   output logic [127:0] read_data,
   output logic         fifo_full,
   output logic         fifo_half_full,
   output logic         fifo_empty,
   output logic         half_pending
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] LOW  = 1'b0;
   localparam logic [0:0] HIGH = 1'b1;
   logic [127:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic [0:0]    r_state;
   logic [63:0]   r_hold;
   logic          w_room, w_acc, w_pop, w_push, w_flush;
   logic [127:0]  w_entry;
   assign w_room  = !fifo_full || read;
   assign w_acc   = write_en && w_room;
   assign w_pop   = read && !fifo_empty;
`ifdef BUS_PACK_FLUSH_EN
   assign w_flush = flush && !write_en && w_room && r_state == HIGH;
`else
   assign w_flush = 1'b0;
`endif
   assign w_push  = (w_acc && r_state == HIGH) || w_flush;
   // A flushed entry carries zeros in the upper half.
   assign w_entry = {w_acc ? write_data : 64'h0, r_hold};
   assign fifo_full      = r_count == (AW+1)'(DEPTH);
   assign fifo_half_full = r_count >= (AW+1)'(DEPTH / 2);
   assign fifo_empty     = r_count == '0;
   assign half_pending   = r_state == HIGH;
   assign read_data      = fifo_empty ? '0 : r_mem[r_rptr];
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wptr] <= w_entry;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_state <= LOW;
         r_hold  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_acc && r_state == LOW) r_hold <= write_data;
         if (w_acc) r_state <= r_state == LOW ? HIGH : LOW;
         else if (w_flush) r_state <= LOW;
      end
endmodule

// File: tb/tb_bus_pack_fifo.sv
// tb_bus_pack_fifo: directed and random stimulus against a queue-based packing model.
module tb_bus_pack_fifo;
   localparam int DEPTH = 8;
`ifdef BUS_PACK_FLUSH_EN
   localparam bit HAS_FLUSH = 1'b1;
`else
   localparam bit HAS_FLUSH = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [63:0]  write_data = '0;
   logic         write_en = 1'b0;
   logic         read = 1'b0;
   logic         flush = 1'b0;
   logic [127:0] read_data;
   logic         fifo_full, fifo_half_full, fifo_empty, half_pending;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [127:0] q[$];
   logic         m_pend = 1'b0;
   logic [63:0]  m_hold = '0;

   always #5 clk = ~clk;

   bus_pack_fifo #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .write_data     (write_data),
      .write_en       (write_en),
      .read           (read),
`ifdef BUS_PACK_FLUSH_EN
      .flush          (flush),
`endif
      .read_data      (read_data),
      .fifo_full      (fifo_full),
      .fifo_half_full (fifo_half_full),
      .fifo_empty     (fifo_empty),
      .half_pending   (half_pending)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".read_data"}, read_data, q.size() != 0 ? q[0] : 128'h0);
      chk({tag, ".empty"}, 128'(fifo_empty), 128'(q.size() == 0));
      chk({tag, ".full"}, 128'(fifo_full), 128'(q.size() == DEPTH));
      chk({tag, ".half_full"}, 128'(fifo_half_full), 128'(q.size() >= DEPTH / 2));
      chk({tag, ".half_pending"}, 128'(half_pending), 128'(m_pend));
   endtask

   task automatic model_reset();
      q.delete();
      m_pend = 1'b0;
      m_hold = '0;
   endtask

   // Drive at the falling edge, update the model at the rising edge, check at the next falling edge.
   task automatic cyc(input logic we, input logic [63:0] wd, input logic rd, input logic fl, input string tag);
      bit full, acc, pop;
      write_en   = we;
      write_data = wd;
      read       = rd;
      flush      = fl && HAS_FLUSH;
      @(posedge clk);
      full = q.size() == DEPTH;
      acc  = we && (!full || rd);
      pop  = rd && q.size() != 0;
      if (pop) void'(q.pop_front());
      if (acc) begin
         if (m_pend) q.push_back({wd, m_hold});
         else m_hold = wd;
         m_pend = !m_pend;
      end else if (flush && m_pend && (!full || rd)) begin
         q.push_back({64'h0, m_hold});
         m_pend = 1'b0;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2;
      check_all("por");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 64'(i), 1'b0, 1'b0, "fill");
         if (i == 7) chk("fill8.half_full", 128'(fifo_half_full), 128'h1);
      end
      chk("fill.full", 128'(fifo_full), 128'h1);
      chk("fill.head", read_data, {64'h1, 64'h0});
      for (int i = 0; i < 8; i++) begin
         chk("drain.head", read_data, {64'(2 * i + 1), 64'(2 * i)});
         cyc(1'b0, '0, 1'b1, 1'b0, "drain");
         if (i == 0) chk("drain.full_drop", 128'(fifo_full), 128'h0);
      end
      chk("drain.empty", 128'(fifo_empty), 128'h1);
      cyc(1'b0, '0, 1'b1, 1'b0, "read_empty");
      cyc(1'b1, 64'hA, 1'b0, 1'b0, "odd_a");
      chk("odd_a.pending", 128'(half_pending), 128'h1);
      chk("odd_a.read_data", read_data, 128'h0);
      cyc(1'b1, 64'hB, 1'b0, 1'b0, "odd_b");
      chk("odd_b.read_data", read_data, {64'hB, 64'hA});
      cyc(1'b0, '0, 1'b1, 1'b0, "odd_pop");
      for (int i = 0; i < 16; i++) cyc(1'b1, 64'(100 + i), 1'b0, 1'b0, "refill");
      cyc(1'b1, 64'd200, 1'b0, 1'b0, "drop_full");
      cyc(1'b1, 64'd201, 1'b1, 1'b0, "full_rw");
      cyc(1'b1, 64'd202, 1'b1, 1'b0, "full_rw2");
      for (int i = 0; i < 3; i++) cyc(1'b1, 64'(300 + i), 1'b0, 1'b0, "refull");
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, "wrap_drain");
      do_reset();
      for (int i = 0; i < 7; i++) cyc(1'b1, 64'(400 + i), 1'b0, 1'b0, "pre_rst");
      chk("pre_rst.pending", 128'(half_pending), 128'h1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      chk("rst_mid.empty", 128'(fifo_empty), 128'h1);
      @(negedge clk);
      rst = 1'b1;
      if (HAS_FLUSH) begin
         cyc(1'b1, 64'hC, 1'b0, 1'b0, "flush_c");
         cyc(1'b0, '0, 1'b0, 1'b1, "flush");
         chk("flush.read_data", read_data, {64'h0, 64'hC});
         cyc(1'b0, '0, 1'b0, 1'b1, "flush_low");
      end
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 9) < (i < 400 ? 3 : 6),
             $urandom_range(0, 3) == 0, "rand");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
